// File: rtl/free_list.sv
//------------------------------------------------------------------------------
// Module      : free_list
// Description : Physical-register free list for a dual-issue rename stage.
//               Supplies up to two destination tags per cycle, accepts up to
//               two freed tags from commit, and keeps a retire-head checkpoint
//               so a flush restores the committed state in one cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module free_list #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_REGS  = 64,
  parameter int PHY_WIDTH = 6,
  parameter int DEPTH     = PHY_REGS - ARCH_REGS,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 alloc_req_0,
  input  logic                 alloc_req_1,
  output logic                 alloc_ready,
  output logic [PHY_WIDTH-1:0] rd_phy_new_0,
  output logic [PHY_WIDTH-1:0] rd_phy_new_1,
  input  logic                 retire_valid_0,
  input  logic                 retire_valid_1,
  input  logic                 free_valid_0,
  input  logic                 free_valid_1,
  input  logic [PHY_WIDTH-1:0] free_phy_0,
  input  logic [PHY_WIDTH-1:0] free_phy_1,
  output logic [PTR_W:0]       free_count,
  output logic                 overflow_err
);

  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

  // Circular storage and the three wrap-extended pointers
  logic [PHY_WIDTH-1:0] r_entry [DEPTH];
  logic [PTR_W:0]       r_head;
  logic [PTR_W:0]       r_retire_head;
  logic [PTR_W:0]       r_tail;
  logic                 r_overflow_err;

  logic [PTR_W:0]   w_need;
  logic [PTR_W:0]   w_free_count;
  logic             w_grant;
  logic [PTR_W-1:0] w_rd_idx0;
  logic [PTR_W-1:0] w_rd_idx1;
  logic [PTR_W:0]   w_retire_next;
  logic [PTR_W:0]   w_occ0;
  logic [PTR_W:0]   w_occ1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_drop;
  logic [PTR_W-1:0] w_wr_idx0;
  logic [PTR_W-1:0] w_wr_idx1;

  // Grant, tag lookup and free-acceptance decisions from registered state
  always_comb begin
    w_need       = (PTR_W+1)'(alloc_req_0) + (PTR_W+1)'(alloc_req_1);
    w_free_count = r_tail - r_head;
    w_grant      = (w_free_count >= w_need) && !flush;

    w_rd_idx0    = r_head[PTR_W-1:0];
    w_rd_idx1    = w_rd_idx0 + PTR_W'(1);

    // Frees arrive with their retiring instruction, so occupancy is measured
    // against the retire head that already includes this cycle's retires.
    w_retire_next = r_retire_head + (PTR_W+1)'(retire_valid_0)
                                  + (PTR_W+1)'(retire_valid_1);
    w_occ0    = r_tail - w_retire_next;
    w_acc0    = free_valid_0 && (w_occ0 < c_DEPTH);
    w_occ1    = w_occ0 + (PTR_W+1)'(w_acc0);
    w_acc1    = free_valid_1 && (w_occ1 < c_DEPTH);
    w_drop    = (free_valid_0 && !w_acc0) || (free_valid_1 && !w_acc1);
    w_wr_idx0 = r_tail[PTR_W-1:0];
    w_wr_idx1 = w_wr_idx0 + PTR_W'(w_acc0);
  end

  assign alloc_ready  = w_grant;
  assign free_count   = w_free_count;
  assign overflow_err = r_overflow_err;
  assign rd_phy_new_0 = r_entry[w_rd_idx0];
  assign rd_phy_new_1 = alloc_req_0 ? r_entry[w_rd_idx1] : r_entry[w_rd_idx0];

  // Pointer, storage and sticky-error update; flush overrides allocation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      r_head         <= '0;
      r_retire_head  <= '0;
      r_tail         <= c_DEPTH;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_acc0) begin
        r_entry[w_wr_idx0] <= free_phy_0;
      end
      if (w_acc1) begin
        r_entry[w_wr_idx1] <= free_phy_1;
      end
      r_tail        <= r_tail + (PTR_W+1)'(w_acc0) + (PTR_W+1)'(w_acc1);
      r_retire_head <= w_retire_next;
      if (flush) begin
        r_head <= w_retire_next;
      end else if (w_grant) begin
        r_head <= r_head + w_need;
      end
      if (w_drop) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
